controle_ajuste_relogio: RTL and testbench

Time-keeping and time-set controller for the digital clock. It generates the one-second count tick that drives the BCD counter chain (seconds, minutes, hours). It also runs the user set-mode state machine and edits minutes and hours in shadow BCD registers. On exit from set mode it issues a single load strobe, which presets the minute and hour counters and clears the seconds counters.

---
 rtl/controle_ajuste_relogio.sv | 124 ++++++++++++
 tb/tb_controle_ajuste_relogio.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/controle_ajuste_relogio.sv
// Time-keeping and time-set controller: one-second prescaler, set-mode FSM,
// shadow BCD edit registers for minutes/hours and a single-cycle load strobe.
module controle_ajuste_relogio #(
    parameter int DIV_SEG = 50000000
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       btnModo,
    input  logic       btnInc,
    input  logic [7:0] curMin,
    input  logic [7:0] curHora,
    output logic       tickSeg,
    output logic       loadRelogio,
    output logic       clearSeg,
    output logic [7:0] loadMin,
    output logic [7:0] loadHora,
    output logic [1:0] modo
);

    localparam int CNT_W = (DIV_SEG > 1) ? $clog2(DIV_SEG) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_SEG - 1);

    localparam logic [1:0] S_RUN      = 2'b00;
    localparam logic [1:0] S_SET_MIN  = 2'b01;
    localparam logic [1:0] S_SET_HORA = 2'b10;
    localparam logic [1:0] S_LOAD     = 2'b11;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_edit_min;
    logic [7:0]       r_edit_hora;
    logic             r_prev_modo;
    logic             r_prev_inc;

    logic             w_press_modo;
    logic             w_press_inc;
    logic [7:0]       w_next_min;
    logic [7:0]       w_next_hora;

    assign w_press_modo = btnModo & ~r_prev_modo;
    assign w_press_inc  = btnInc & ~r_prev_inc;

    // Any value outside 00..59 (including non-BCD copies from curMin) wraps to 00.
    always_comb begin
        w_next_min = 8'h00;
        if (r_edit_min[7:4] > 4'd5 || r_edit_min[3:0] > 4'd9 || r_edit_min == 8'h59)
            w_next_min = 8'h00;
        else if (r_edit_min[3:0] == 4'd9)
            w_next_min = {r_edit_min[7:4] + 4'd1, 4'd0};
        else
            w_next_min = {r_edit_min[7:4], r_edit_min[3:0] + 4'd1};
    end

    always_comb begin
        w_next_hora = 8'h00;
        if (r_edit_hora[7:4] > 4'd2 || r_edit_hora[3:0] > 4'd9 ||
            (r_edit_hora[7:4] == 4'd2 && r_edit_hora[3:0] >= 4'd3))
            w_next_hora = 8'h00;
        else if (r_edit_hora[3:0] == 4'd9)
            w_next_hora = {r_edit_hora[7:4] + 4'd1, 4'd0};
        else
            w_next_hora = {r_edit_hora[7:4], r_edit_hora[3:0] + 4'd1};
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_prev_modo <= 1'b0;
            r_prev_inc  <= 1'b0;
        end else begin
            r_prev_modo <= btnModo;
            r_prev_inc  <= btnInc;
        end
    end

    // A mode press always wins over a simultaneous increment press.
    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= S_RUN;
            r_edit_min  <= 8'h00;
            r_edit_hora <= 8'h00;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_press_modo) begin
                        r_state     <= S_SET_MIN;
                        r_edit_min  <= curMin;
                        r_edit_hora <= curHora;
                    end
                end
                S_SET_MIN: begin
                    if (w_press_modo)
                        r_state <= S_SET_HORA;
                    else if (w_press_inc)
                        r_edit_min <= w_next_min;
                end
                S_SET_HORA: begin
                    if (w_press_modo)
                        r_state <= S_LOAD;
                    else if (w_press_inc)
                        r_edit_hora <= w_next_hora;
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Prescaler runs only in RUN so editing never advances the seconds.
    always_ff @(posedge clk) begin
        if (clear)
            r_cnt <= '0;
        else if (r_state == S_RUN)
            r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
        else
            r_cnt <= '0;
    end

    assign tickSeg     = (r_state == S_RUN) && (r_cnt == CNT_MAX);
    assign loadRelogio = (r_state == S_LOAD);
    assign clearSeg    = (r_state == S_LOAD);
    assign loadMin     = r_edit_min;
    assign loadHora    = r_edit_hora;
    assign modo        = r_state;

endmodule

// File: tb/tb_controle_ajuste_relogio.sv
// Bench for controle_ajuste_relogio with DIV_SEG=4: decimal reference model
// feeding an expected-output queue, plus directed checks on key values.
module tb_controle_ajuste_relogio;

    localparam int DIV = 4;

    logic       clk;
    logic       clear;
    logic       btnModo;
    logic       btnInc;
    logic [7:0] curMin;
    logic [7:0] curHora;
    logic       tickSeg;
    logic       loadRelogio;
    logic       clearSeg;
    logic [7:0] loadMin;
    logic [7:0] loadHora;
    logic [1:0] modo;

    controle_ajuste_relogio #(.DIV_SEG(DIV)) dut (
        .clk(clk), .clear(clear), .btnModo(btnModo), .btnInc(btnInc),
        .curMin(curMin), .curHora(curHora), .tickSeg(tickSeg),
        .loadRelogio(loadRelogio), .clearSeg(clearSeg), .loadMin(loadMin),
        .loadHora(loadHora), .modo(modo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [20:0] exp_q[$];

    // Reference model: edit values kept as decimal integers.
    int m_state = 0;
    int m_cnt   = 0;
    int m_min   = 0;
    int m_hora  = 0;
    bit m_pm    = 0;
    bit m_pi    = 0;
    bit saw_load;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic logic [20:0] model_outs();
        logic tk;
        logic ld;
        tk = (m_state == 0) && (m_cnt == DIV - 1);
        ld = (m_state == 3);
        return {tk, ld, ld, 2'(m_state), int2bcd(m_min), int2bcd(m_hora)};
    endfunction

    task automatic model_step(input bit m, input bit i, input bit c);
        bit pm_press;
        bit pi_press;
        if (c) begin
            m_state = 0; m_cnt = 0; m_min = 0; m_hora = 0; m_pm = 0; m_pi = 0;
        end else begin
            pm_press = m && !m_pm;
            pi_press = i && !m_pi;
            if (m_state == 0) m_cnt = (m_cnt + 1) % DIV;
            else m_cnt = 0;
            case (m_state)
                0: if (pm_press) begin
                    m_state = 1; m_min = bcd2int(curMin); m_hora = bcd2int(curHora);
                end
                1: if (pm_press) m_state = 2;
                   else if (pi_press) m_min = (m_min + 1) % 60;
                2: if (pm_press) m_state = 3;
                   else if (pi_press) m_hora = (m_hora + 1) % 24;
                default: m_state = 0;
            endcase
            m_pm = m; m_pi = i;
        end
    endtask

    task automatic drive(input bit m, input bit i, input bit c);
        logic [20:0] got;
        btnModo = m; btnInc = i; clear = c;
        model_step(m, i, c);
        exp_q.push_back(model_outs());
        @(posedge clk);
        #1;
        got = {tickSeg, loadRelogio, clearSeg, modo, loadMin, loadHora};
        check("cycle", 32'(got), 32'(exp_q.pop_front()));
        saw_load = saw_load | loadRelogio;
    endtask

    initial begin
        logic [7:0] min_steps [3];
        min_steps[0] = 8'h59; min_steps[1] = 8'h00; min_steps[2] = 8'h01;
        clear = 1'b1; btnModo = 1'b0; btnInc = 1'b0;
        curMin = 8'h09; curHora = 8'h09;

        // Reset and free-running tick: cycles 4, 8, 12 after clear.
        drive(0, 0, 1);
        check("reset_out", 32'({tickSeg, loadRelogio, clearSeg, modo, loadMin, loadHora}), 32'h0);
        for (int k = 1; k <= 11; k++) begin
            drive(0, 0, 0);
            check("tick_free", 32'(tickSeg), 32'(((k + 1) % 4) == 0));
        end

        // Tick suppression in SET_MIN with editMin=09.
        drive(1, 0, 0);
        check("enter_set_min", 32'(modo), 32'h1);
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0);
            check("tick_suppr", 32'(tickSeg), 32'h0);
        end

        // Simultaneous modo+inc: modo wins.
        drive(1, 1, 0);
        check("simul_modo", 32'(modo), 32'h2);
        check("simul_min", 32'(loadMin), 32'h09);
        drive(0, 0, 0);

        // Held inc in SET_HORA from 09 increments once.
        for (int k = 0; k < 10; k++) drive(0, 1, 0);
        check("held_inc", 32'(loadHora), 32'h10);
        drive(0, 0, 0);
        drive(1, 0, 0);
        check("load_a", 32'({modo, loadRelogio, clearSeg}), 32'b1111);
        for (int j = 1; j <= 6; j++) begin
            drive(0, 0, 0);
            check("tick_after_load", 32'(tickSeg), 32'(j == 4));
        end

        // Full edit with wrap from 58 / 23.
        curMin = 8'h58; curHora = 8'h23;
        drive(1, 0, 0);
        check("edit_modo01", 32'(modo), 32'h1);
        drive(0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0);
            check("edit_min_step", 32'(loadMin), 32'(min_steps[k]));
            drive(0, 0, 0);
        end
        drive(1, 0, 0);
        check("edit_modo10", 32'(modo), 32'h2);
        drive(0, 0, 0);
        drive(0, 1, 0);
        check("edit_hora_wrap", 32'(loadHora), 32'h00);
        drive(0, 0, 0);
        drive(1, 0, 0);
        check("load_modo", 32'(modo), 32'h3);
        check("load_strobes", 32'({loadRelogio, clearSeg}), 32'b11);
        check("load_vals", 32'({loadMin, loadHora}), 32'h0100);
        drive(0, 0, 0);
        check("after_load", 32'({modo, loadRelogio, clearSeg}), 32'h0);

        // Reset mid-edit in SET_HORA.
        curMin = 8'h30; curHora = 8'h05;
        saw_load = 1'b0;
        drive(1, 0, 0); drive(0, 0, 0);
        drive(1, 0, 0); drive(0, 0, 0);
        drive(0, 1, 0); drive(0, 0, 0);
        drive(0, 1, 0); drive(0, 0, 0);
        check("mid_hora", 32'(loadHora), 32'h07);
        drive(0, 0, 1);
        check("mid_clear", 32'({modo, loadMin, loadHora}), 32'h0);
        drive(0, 0, 0);
        check("mid_no_load", 32'(saw_load), 32'h0);

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            curMin  = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            curHora = ($urandom_range(0, 1) == 1) ? {4'd2, 4'($urandom_range(0, 3))}
                                                   : {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
            drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 79) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
